// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: decoded instruction, dispatch packet,
// reservation-station selectors and register-alias-table entries.
package rv32i_types;

  localparam int RV_ROB_DEPTH = 32;
  localparam int RV_TAG_LEN   = $clog2(RV_ROB_DEPTH) - 1;

  typedef logic [RV_TAG_LEN:0] tag_t;

  // Reservation-station selectors carried in rs_type.
  localparam logic [1:0] RS_ADD = 2'b00;
  localparam logic [1:0] RS_MUL = 2'b01;
  localparam logic [1:0] RS_LSQ = 2'b10;
  localparam logic [1:0] RS_BR  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  aluop;
    logic [2:0]  cmp;
    logic [1:0]  rs_type;
    logic        use_pc;
    logic        use_imm;
  } decode_t;

  typedef struct packed {
    logic        valid;
    tag_t        rob_num;
    logic [1:0]  rs_type;
    logic [2:0]  aluop;
    logic [2:0]  cmp;
    logic [31:0] vj;
    logic        rj;
    tag_t        qj;
    logic [31:0] vk;
    logic        rk;
    tag_t        qk;
  } dis_ex_t;

  typedef struct packed {
    logic busy;
    tag_t tag;
  } rat_entry_t;

endpackage

// File: rtl/dispatch_rename_rat.sv
// 32-entry register alias table: two combinational read ports, one rename
// write, a tag-matched commit clear and a whole-table flush of busy bits.
module rat
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic [4:0] i_rd_addr1,
  input  logic [4:0] i_rd_addr2,
  output rat_entry_t o_rd_ent1,
  output rat_entry_t o_rd_ent2,
  input  logic       i_ren_en,
  input  logic [4:0] i_ren_rd,
  input  tag_t       i_ren_tag,
  input  logic       i_cm_en,
  input  logic [4:0] i_cm_rd,
  input  tag_t       i_cm_tag
);

  rat_entry_t r_tab [32];

  assign o_rd_ent1 = r_tab[i_rd_addr1];
  assign o_rd_ent2 = r_tab[i_rd_addr2];

  // Table update: flush beats everything, a rename beats a commit to the same rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_tab[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < 32; i++) r_tab[i].busy <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (i_ren_en && (i_ren_rd == 5'(i))) begin
          r_tab[i].busy <= 1'b1;
          r_tab[i].tag  <= i_ren_tag;
        end else if (i_cm_en && (i_cm_rd == 5'(i)) && (i_cm_tag == r_tab[i].tag)) begin
          r_tab[i].busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_rename.sv
// Rename/dispatch register: accepts one decoded instruction per cycle,
// allocates the ROB tail tag, resolves operands and holds the packet while
// the target reservation station is full, snooping the CDB meanwhile.
module dispatch_rename
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH = RV_ROB_DEPTH,
  parameter int TAG_LEN   = $clog2(ROB_DEPTH) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_mispredicted,
  input  logic               iq_valid,
  input  decode_t            iq_inst,
  output logic               iq_ready,
  input  logic               rob_full,
  input  logic [TAG_LEN:0]   rob_tail_tag,
  output logic               rob_alloc,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  input  logic [31:0]        rf_rs1_data,
  input  logic [31:0]        rf_rs2_data,
  output logic [TAG_LEN:0]   rob_rd_tag1,
  output logic [TAG_LEN:0]   rob_rd_tag2,
  input  logic               rob_rd_rdy1,
  input  logic               rob_rd_rdy2,
  input  logic [31:0]        rob_rd_data1,
  input  logic [31:0]        rob_rd_data2,
  input  logic [TAG_LEN:0]   cdb_tag1,
  input  logic [TAG_LEN:0]   cdb_tag2,
  input  logic [TAG_LEN:0]   cdb_tag3,
  input  logic [TAG_LEN:0]   cdb_tag4,
  input  logic [31:0]        cdb_result1,
  input  logic [31:0]        cdb_result2,
  input  logic [31:0]        cdb_result3,
  input  logic [31:0]        cdb_result4,
  input  logic               update_rob,
  input  logic               update_mul,
  input  logic               update_lsq,
  input  logic               update_bp,
  input  logic               commit_valid,
  input  logic [4:0]         commit_rd,
  input  logic [TAG_LEN:0]   commit_tag,
  input  logic [31:0]        commit_data,
  input  logic               add_full,
  input  logic               mul_full,
  input  logic               lsq_full,
  input  logic               br_full,
  output dis_ex_t            dis_ex_reg
);

  typedef struct packed {
    logic        rdy;
    logic [31:0] data;
    tag_t        q;
  } opnd_t;

  // Wake a waiting operand from the CDB; the lowest-numbered source wins.
  function automatic opnd_t f_snoop(input opnd_t cur, input logic [3:0] cdb_v,
                                    input tag_t [3:0] cdb_tag,
                                    input logic [3:0][31:0] cdb_val);
    opnd_t o;
    o = cur;
    for (int k = 0; k < 4; k++) begin
      if (!o.rdy && cdb_v[k] && (cdb_tag[k] == cur.q)) begin
        o.rdy  = 1'b1;
        o.data = cdb_val[k];
        o.q    = '0;
      end
    end
    return o;
  endfunction

  // Source resolution: x0, idle/committing RAT entry, CDB, ROB, else wait on tag.
  function automatic opnd_t f_resolve(input logic [4:0] addr, input rat_entry_t ent,
                                      input logic [31:0] rf_data,
                                      input logic cm_v, input logic [4:0] cm_rd,
                                      input tag_t cm_tag, input logic [31:0] cm_data,
                                      input logic [3:0] cdb_v, input tag_t [3:0] cdb_tag,
                                      input logic [3:0][31:0] cdb_val,
                                      input logic rob_rdy, input logic [31:0] rob_data);
    opnd_t o;
    o = '{rdy: 1'b0, data: 32'd0, q: ent.tag};
    if (addr == 5'd0) begin
      o = '{rdy: 1'b1, data: 32'd0, q: '0};
    end else if (!ent.busy) begin
      o = '{rdy: 1'b1, data: rf_data, q: '0};
    end else if (cm_v && (cm_rd == addr) && (cm_tag == ent.tag)) begin
      o = '{rdy: 1'b1, data: cm_data, q: '0};
    end else begin
      o = f_snoop(o, cdb_v, cdb_tag, cdb_val);
      if (!o.rdy && rob_rdy) o = '{rdy: 1'b1, data: rob_data, q: '0};
    end
    return o;
  endfunction

  dis_ex_t            r_dis_p1;
  dis_ex_t            w_next;
  rat_entry_t         w_ent1, w_ent2;
  opnd_t              w_op1, w_op2, w_snp1, w_snp2;
  logic [3:0]         w_cdb_v;
  tag_t [3:0]         w_cdb_tag;
  logic [3:0][31:0]   w_cdb_val;
  logic               w_full_sel, w_stall, w_accept, w_vld_p1;

  assign w_cdb_v   = {update_bp, update_lsq, update_mul, update_rob};
  assign w_cdb_tag = {cdb_tag4, cdb_tag3, cdb_tag2, cdb_tag1};
  assign w_cdb_val = {cdb_result4, cdb_result3, cdb_result2, cdb_result1};

  assign w_vld_p1 = r_dis_p1.valid;

  // Full flag of the station the held packet is headed for.
  always_comb begin
    w_full_sel = add_full;
    case (r_dis_p1.rs_type)
      RS_ADD:  w_full_sel = add_full;
      RS_MUL:  w_full_sel = mul_full;
      RS_LSQ:  w_full_sel = lsq_full;
      default: w_full_sel = br_full;
    endcase
  end

  assign w_stall   = w_vld_p1 && w_full_sel;
  assign iq_ready  = !rst && !branch_mispredicted && !rob_full && !w_stall;
  assign w_accept  = iq_valid && iq_ready;
  assign rob_alloc = w_accept;

  assign rs1_addr    = iq_inst.rs1;
  assign rs2_addr    = iq_inst.rs2;
  assign rob_rd_tag1 = w_ent1.tag;
  assign rob_rd_tag2 = w_ent2.tag;

  rat u_rat (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (branch_mispredicted),
    .i_rd_addr1 (iq_inst.rs1),
    .i_rd_addr2 (iq_inst.rs2),
    .o_rd_ent1  (w_ent1),
    .o_rd_ent2  (w_ent2),
    .i_ren_en   (w_accept && (iq_inst.rd != 5'd0)),
    .i_ren_rd   (iq_inst.rd),
    .i_ren_tag  (rob_tail_tag),
    .i_cm_en    (commit_valid),
    .i_cm_rd    (commit_rd),
    .i_cm_tag   (commit_tag)
  );

  // Resolve both incoming sources and wake the held packet's waiting sources.
  always_comb begin
    w_op1 = f_resolve(iq_inst.rs1, w_ent1, rf_rs1_data, commit_valid, commit_rd,
                      commit_tag, commit_data, w_cdb_v, w_cdb_tag, w_cdb_val,
                      rob_rd_rdy1, rob_rd_data1);
    w_op2 = f_resolve(iq_inst.rs2, w_ent2, rf_rs2_data, commit_valid, commit_rd,
                      commit_tag, commit_data, w_cdb_v, w_cdb_tag, w_cdb_val,
                      rob_rd_rdy2, rob_rd_data2);
    if (iq_inst.use_pc)  w_op1 = '{rdy: 1'b1, data: iq_inst.pc,  q: '0};
    if (iq_inst.use_imm) w_op2 = '{rdy: 1'b1, data: iq_inst.imm, q: '0};
    w_snp1 = f_snoop('{rdy: r_dis_p1.rj, data: r_dis_p1.vj, q: r_dis_p1.qj},
                     w_cdb_v, w_cdb_tag, w_cdb_val);
    w_snp2 = f_snoop('{rdy: r_dis_p1.rk, data: r_dis_p1.vk, q: r_dis_p1.qk},
                     w_cdb_v, w_cdb_tag, w_cdb_val);
  end

  // Next packet: flush, then accept, then hold-and-snoop, else drain.
  always_comb begin
    w_next = r_dis_p1;
    if (branch_mispredicted) begin
      w_next.valid = 1'b0;
    end else if (w_accept) begin
      w_next.valid   = 1'b1;
      w_next.rob_num = rob_tail_tag;
      w_next.rs_type = iq_inst.rs_type;
      w_next.aluop   = iq_inst.aluop;
      w_next.cmp     = iq_inst.cmp;
      w_next.vj      = w_op1.data;
      w_next.rj      = w_op1.rdy;
      w_next.qj      = w_op1.q;
      w_next.vk      = w_op2.data;
      w_next.rk      = w_op2.rdy;
      w_next.qk      = w_op2.q;
    end else if (w_stall) begin
      w_next.vj = w_snp1.data;
      w_next.rj = w_snp1.rdy;
      w_next.qj = w_snp1.q;
      w_next.vk = w_snp2.data;
      w_next.rk = w_snp2.rdy;
      w_next.qk = w_snp2.q;
    end else begin
      w_next.valid = 1'b0;
    end
  end

  // ---- stage boundary: resolved instruction -> dispatch packet (p1) ----
  // Dispatch packet register.
  always_ff @(posedge clk) begin
    if (rst) r_dis_p1 <= '0;
    else     r_dis_p1 <= w_next;
  end

  assign dis_ex_reg = r_dis_p1;

endmodule
